// File: rtl/laser_pkg.sv
// rtl/laser_pkg.sv - shared state type, state width and channel-select width helper
package laser_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    ON   = 2'd2,
    COOL = 2'd3
  } state_t;

  // Channel-select width: at least one bit even for a single channel.
  function automatic int chw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/laser_pulse_ctrl_if.sv
// rtl/laser_pulse_ctrl_if.sv - operator request and laser status bundle
interface laser_pulse_ctrl_if
  import laser_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int NCH   = 4
);
  localparam int CHW = chw(NCH);

  logic             b;
  logic             abort;
  logic [CHW-1:0]   ch_sel;
  logic [NBITS-1:0] dur;
  logic [NCH-1:0]   light;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             err;

  modport master (
    output b, abort, ch_sel, dur,
    input  light, busy, done, aborted, err
  );

  modport slave (
    input  b, abort, ch_sel, dur,
    output light, busy, done, aborted, err
  );

endinterface

// File: rtl/laser_timer.sv
// rtl/laser_timer.sv - loadable down-counter shared by the ON and COOL phases
module laser_timer #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [NBITS-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [NBITS-1:0] count;

  // Saturates at zero so an idle enable never wraps the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - NBITS'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/laser_pulse_ctrl.sv
// rtl/laser_pulse_ctrl.sv - multi-channel fire/arm/on laser pulse controller
// Optional post-pulse cooldown state enabled by defining LASER_COOL_EN.
module laser_pulse_ctrl
  import laser_pkg::*;
#(
  parameter int NBITS       = 32,
  parameter int NCH         = 4,
  parameter int COOL_CYCLES = 25000000
) (
  input  logic               clk,
  input  logic               reset,
  laser_pulse_ctrl_if.slave  bus
);

  localparam int CHW = chw(NCH);

`ifdef LASER_COOL_EN
  localparam state_t EXIT_ST = COOL;
`else
  localparam state_t EXIT_ST = IDLE;
`endif

  state_t           state;
  state_t           next;
  logic             b_q;
  logic [CHW-1:0]   ch_q;
  logic [NBITS-1:0] dur_q;
  logic             fire;
  logic             req_bad;
  logic             zero;
  logic             t_load;
  logic [NBITS-1:0] t_val;
  logic             t_en;

  logic [NCH-1:0]   light_q, light_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             err_q, err_d;

  assign fire    = bus.b & ~b_q;
  assign req_bad = (bus.dur == '0) || (int'(bus.ch_sel) >= NCH);

  laser_timer #(.NBITS(NBITS)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .zero     (zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      b_q       <= 1'b1;
      ch_q      <= '0;
      dur_q     <= '0;
      light_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= next;
      b_q       <= bus.b;
      if ((state == IDLE) && fire && !req_bad) begin
        ch_q  <= bus.ch_sel;
        dur_q <= bus.dur;
      end
      light_q   <= light_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (fire && !req_bad) next = ARM;
      ARM:  next = bus.abort ? EXIT_ST : ON;
      ON:   if (bus.abort || zero) next = EXIT_ST;
`ifdef LASER_COOL_EN
      COOL: if (zero) next = IDLE;
`endif
      default: next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    light_d   = '0;
    busy_d    = (next != IDLE);
    done_d    = 1'b0;
    aborted_d = 1'b0;
    err_d     = 1'b0;
    t_load    = 1'b0;
    t_val     = '0;
    t_en      = 1'b0;
    if (next == ON) light_d = NCH'(1) << ch_q;
    case (state)
      IDLE: err_d = fire && req_bad;
      ARM: begin
        aborted_d = bus.abort;
        if (!bus.abort) begin
          t_load = 1'b1;
          t_val  = dur_q - NBITS'(1);
        end
      end
      ON: begin
        aborted_d = bus.abort;
        done_d    = !bus.abort && zero;
        t_en      = 1'b1;
      end
      default: t_en = 1'b1;
    endcase
    if ((next == COOL) && (state != COOL)) begin
      t_load = 1'b1;
      t_val  = NBITS'(COOL_CYCLES - 1);
    end
  end

  assign bus.light   = light_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_laser_pulse_ctrl.sv
// tb/tb_laser_pulse_ctrl.sv - scoreboard bench for laser_pulse_ctrl (NBITS=8, NCH=4, COOL_CYCLES=3)
module tb_laser_pulse_ctrl;

  localparam int NB = 8;
  localparam int NC = 4;
  localparam int CC = 3;
`ifdef LASER_COOL_EN
  localparam logic BUSY_AT_DONE = 1'b1;
`else
  localparam logic BUSY_AT_DONE = 1'b0;
`endif

  typedef enum int {K_DONE, K_ABORT, K_ERR, K_NONE} kind_e;
  typedef struct {
    kind_e         kind;
    logic [NC-1:0] light;
    int            len;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  laser_pulse_ctrl_if #(.NBITS(NB), .NCH(NC)) bus ();
  laser_pulse_ctrl_if #(.NBITS(NB), .NCH(3))  bus2 ();

  laser_pulse_ctrl #(.NBITS(NB), .NCH(NC), .COOL_CYCLES(CC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  laser_pulse_ctrl #(.NBITS(NB), .NCH(3), .COOL_CYCLES(CC)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int            light_cycles = 0;
  int            done_cnt = 0;
  int            abort_cnt = 0;
  int            multi_hot = 0;
  logic [NC-1:0] light_last = '0;

  always @(negedge clk) begin
    if (bus.light != '0) begin
      light_cycles++;
      light_last = bus.light;
    end
    if ($countones(bus.light) > 1) multi_hot++;
    if (bus.done === 1'b1) done_cnt++;
    if (bus.aborted === 1'b1) abort_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_outcome(input int limit, output kind_e k, output int cyc);
    k = K_NONE;
    cyc = 0;
    while (k == K_NONE && cyc < limit) begin
      step();
      cyc++;
      if (bus.done === 1'b1) k = K_DONE;
      else if (bus.aborted === 1'b1) k = K_ABORT;
      else if (bus.err === 1'b1) k = K_ERR;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.b = 1'b0;  bus.abort = 1'b0;  bus.ch_sel = '0;  bus.dur = '0;
    bus2.b = 1'b0; bus2.abort = 1'b0; bus2.ch_sel = '0; bus2.dur = '0;
    repeat (3) step();
    total++; if (bus.light !== 4'b0000) $display("FAIL reset_light: got %b want 0000", bus.light); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    total++; if ({bus.done, bus.aborted, bus.err} !== 3'b000)
      $display("FAIL reset_pulses: got %b want 000", {bus.done, bus.aborted, bus.err}); else passed++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_normal();
    int lc0, cyc;
    kind_e k;
    exp_t e;
    bus.ch_sel = 2'd2; bus.dur = 8'd5;
    sb.push_back('{kind: K_DONE, light: 4'b0100, len: 5});
    lc0 = light_cycles;
    bus.b = 1'b1;
    step();
    total++; if ({bus.busy, bus.light} !== 5'b1_0000)
      $display("FAIL normal_arm: got busy,light=%b want 10000", {bus.busy, bus.light}); else passed++;
    bus.ch_sel = 2'd0; bus.dur = 8'd1; bus.b = 1'b0;
    step();
    total++; if (bus.light !== 4'b0100) $display("FAIL normal_first_light: got %b want 0100", bus.light); else passed++;
    wait_outcome(40, k, cyc);
    e = sb.pop_front();
    total++; if (k !== e.kind) $display("FAIL normal_kind: got %0d want %0d", k, e.kind); else passed++;
    total++; if (cyc !== 5) $display("FAIL normal_latency: got %0d want 5", cyc); else passed++;
    total++; if (light_cycles - lc0 !== e.len) $display("FAIL normal_len: got %0d want %0d", light_cycles - lc0, e.len); else passed++;
    total++; if (light_last !== e.light) $display("FAIL normal_chan: got %b want %b", light_last, e.light); else passed++;
    total++; if ({bus.light, bus.busy} !== {4'b0000, BUSY_AT_DONE})
      $display("FAIL normal_done_cycle: got light,busy=%b want %b", {bus.light, bus.busy}, {4'b0000, BUSY_AT_DONE}); else passed++;
    step();
    total++; if (bus.done !== 1'b0) $display("FAIL normal_done_width: got %b want 0", bus.done); else passed++;
    repeat (CC + 2) step();
    total++; if (bus.busy !== 1'b0) $display("FAIL normal_release: got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_min_dur();
    int lc0, cyc;
    kind_e k;
    exp_t e;
    bus.ch_sel = 2'd3; bus.dur = 8'd1;
    sb.push_back('{kind: K_DONE, light: 4'b1000, len: 1});
    lc0 = light_cycles;
    bus.b = 1'b1;
    step();
    bus.b = 1'b0;
    wait_outcome(20, k, cyc);
    e = sb.pop_front();
    total++; if (k !== e.kind) $display("FAIL min_kind: got %0d want %0d", k, e.kind); else passed++;
    total++; if (light_cycles - lc0 !== e.len) $display("FAIL min_len: got %0d want %0d", light_cycles - lc0, e.len); else passed++;
    total++; if (light_last !== e.light) $display("FAIL min_chan: got %b want %b", light_last, e.light); else passed++;
    repeat (CC + 2) step();
  endtask

  task automatic test_reject();
    int lc0, cyc;
    kind_e k;
    exp_t e;
    bus.ch_sel = 2'd1; bus.dur = 8'd0;
    sb.push_back('{kind: K_ERR, light: 4'b0000, len: 0});
    lc0 = light_cycles;
    bus.b = 1'b1;
    wait_outcome(5, k, cyc);
    e = sb.pop_front();
    total++; if (k !== e.kind) $display("FAIL reject_kind: got %0d want %0d", k, e.kind); else passed++;
    total++; if (cyc !== 1) $display("FAIL reject_latency: got %0d want 1", cyc); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reject_busy: got %b want 0", bus.busy); else passed++;
    bus.b = 1'b0;
    step();
    total++; if (bus.err !== 1'b0) $display("FAIL reject_err_width: got %b want 0", bus.err); else passed++;
    repeat (4) step();
    total++; if (light_cycles - lc0 !== e.len) $display("FAIL reject_light: got %0d want %0d", light_cycles - lc0, e.len); else passed++;
    bus2.ch_sel = 2'd3; bus2.dur = 8'd4; bus2.b = 1'b1;
    step();
    total++; if ({bus2.err, bus2.busy} !== 2'b10)
      $display("FAIL reject_chan_range: got err,busy=%b want 10", {bus2.err, bus2.busy}); else passed++;
    bus2.b = 1'b0;
    step();
    total++; if ({bus2.light, bus2.busy, bus2.err} !== 5'b000_0_0)
      $display("FAIL reject_chan_after: got %b want 00000", {bus2.light, bus2.busy, bus2.err}); else passed++;
  endtask

  task automatic test_abort();
    int lc0, d0;
    kind_e k;
    exp_t e;
    bus.ch_sel = 2'd1; bus.dur = 8'd10;
    sb.push_back('{kind: K_ABORT, light: 4'b0010, len: 3});
    lc0 = light_cycles;
    d0 = done_cnt;
    bus.b = 1'b1;
    step();
    bus.b = 1'b0;
    repeat (3) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    k = (bus.aborted === 1'b1) ? K_ABORT : ((bus.done === 1'b1) ? K_DONE : K_NONE);
    e = sb.pop_front();
    total++; if (k !== e.kind) $display("FAIL abort_kind: got %0d want %0d", k, e.kind); else passed++;
    total++; if (bus.light !== 4'b0000) $display("FAIL abort_light: got %b want 0000", bus.light); else passed++;
    total++; if (light_cycles - lc0 !== e.len) $display("FAIL abort_len: got %0d want %0d", light_cycles - lc0, e.len); else passed++;
    total++; if (light_last !== e.light) $display("FAIL abort_chan: got %b want %b", light_last, e.light); else passed++;
    step();
    total++; if (bus.aborted !== 1'b0) $display("FAIL abort_width: got %b want 0", bus.aborted); else passed++;
    repeat (15) step();
    total++; if (done_cnt - d0 !== 0) $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL abort_release: got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_ignored();
    int lc0, d0;
    exp_t e;
    bus.ch_sel = 2'd3; bus.dur = 8'd4;
    sb.push_back('{kind: K_DONE, light: 4'b1000, len: 4});
    lc0 = light_cycles;
    d0 = done_cnt;
    bus.b = 1'b1;
    repeat (20) step();
    bus.b = 1'b0;
    repeat (CC + 6) step();
    e = sb.pop_front();
    total++; if (done_cnt - d0 !== 1) $display("FAIL held_done_count: got %0d want 1", done_cnt - d0); else passed++;
    total++; if (light_cycles - lc0 !== e.len) $display("FAIL held_len: got %0d want %0d", light_cycles - lc0, e.len); else passed++;

    bus.ch_sel = 2'd0; bus.dur = 8'd6;
    sb.push_back('{kind: K_DONE, light: 4'b0001, len: 6});
    lc0 = light_cycles;
    d0 = done_cnt;
    bus.b = 1'b1;
    step();
    bus.b = 1'b0;
    repeat (2) step();
    bus.b = 1'b1;
    step();
    bus.b = 1'b0;
    repeat (14) step();
    e = sb.pop_front();
    total++; if (done_cnt - d0 !== 1) $display("FAIL reedge_done_count: got %0d want 1", done_cnt - d0); else passed++;
    total++; if (light_cycles - lc0 !== e.len) $display("FAIL reedge_len: got %0d want %0d", light_cycles - lc0, e.len); else passed++;
    total++; if (light_last !== e.light) $display("FAIL reedge_chan: got %b want %b", light_last, e.light); else passed++;
  endtask

  task automatic test_cooldown();
    int lc0, cyc, nb;
    kind_e k;
    exp_t e;
    bus.ch_sel = 2'd1; bus.dur = 8'd2;
    sb.push_back('{kind: K_DONE, light: 4'b0010, len: 2});
    lc0 = light_cycles;
    bus.b = 1'b1;
    step();
    bus.b = 1'b0;
    wait_outcome(20, k, cyc);
    e = sb.pop_front();
    total++; if (k !== e.kind) $display("FAIL cool_kind: got %0d want %0d", k, e.kind); else passed++;
    total++; if (light_cycles - lc0 !== e.len) $display("FAIL cool_len: got %0d want %0d", light_cycles - lc0, e.len); else passed++;
`ifdef LASER_COOL_EN
    bus.b = 1'b1;
    nb = 0;
    while (bus.busy === 1'b1 && nb < 10) begin
      nb++;
      step();
      bus.b = 1'b0;
    end
    total++; if (nb !== CC) $display("FAIL cool_busy_cycles: got %0d want %0d", nb, CC); else passed++;
    repeat (6) step();
    total++; if (light_cycles - lc0 !== e.len) $display("FAIL cool_ignored: got %0d want %0d", light_cycles - lc0, e.len); else passed++;
`else
    total++; if (bus.busy !== 1'b0) $display("FAIL cool_busy_drop: got %b want 0", bus.busy); else passed++;
    sb.push_back('{kind: K_DONE, light: 4'b0010, len: 2});
    bus.b = 1'b1;
    step();
    bus.b = 1'b0;
    nb = bus.busy;
    total++; if (nb !== 1) $display("FAIL b2b_accept: got busy=%0d want 1", nb); else passed++;
    wait_outcome(20, k, cyc);
    e = sb.pop_front();
    total++; if (k !== e.kind) $display("FAIL b2b_kind: got %0d want %0d", k, e.kind); else passed++;
    total++; if (light_cycles - lc0 !== 2 * e.len) $display("FAIL b2b_len: got %0d want %0d", light_cycles - lc0, 2 * e.len); else passed++;
    repeat (3) step();
`endif
  endtask

  task automatic test_reset_mid();
    int lc0, d0, a0;
    bus.ch_sel = 2'd2; bus.dur = 8'd8;
    bus.b = 1'b1;
    step();
    bus.b = 1'b0;
    repeat (3) step();
    total++; if (bus.light !== 4'b0100) $display("FAIL rst_mid_on: got %b want 0100", bus.light); else passed++;
    reset = 1'b1;
    bus.b = 1'b1;
    step();
    total++; if ({bus.light, bus.busy, bus.done, bus.aborted} !== 7'b0000_000)
      $display("FAIL rst_mid_drop: got %b want 0000000", {bus.light, bus.busy, bus.done, bus.aborted}); else passed++;
    lc0 = light_cycles;
    d0 = done_cnt;
    a0 = abort_cnt;
    step();
    reset = 1'b0;
    repeat (12) step();
    total++; if (light_cycles - lc0 !== 0) $display("FAIL rst_held_b: got %0d light cycles want 0", light_cycles - lc0); else passed++;
    total++; if ((done_cnt - d0) + (abort_cnt - a0) !== 0)
      $display("FAIL rst_no_pulse: got %0d want 0", (done_cnt - d0) + (abort_cnt - a0)); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else passed++;
    bus.b = 1'b0;
    step();
  endtask

  task automatic test_invariants();
    total++; if (multi_hot !== 0) $display("FAIL one_hot: got %0d multi-hot cycles want 0", multi_hot); else passed++;
    total++; if (sb.size() !== 0) $display("FAIL scoreboard_empty: got %0d want 0", sb.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_min_dur();
    test_reject();
    test_abort();
    test_ignored();
    test_cooldown();
    test_reset_mid();
    test_invariants();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
